pwm_capture: RTL and testbench



---
 rtl/pwm_capture.sv | 108 ++++++++++
 tb/tb_pwm_capture.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM waveform and
// reports an 8-bit duty ratio computed by a bit-serial restoring divider.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic [7:0]       duty_out,
  output logic             valid,
  output logic             stuck,
  output logic             overrun
);
  localparam logic [1:0] IDLE = 2'd0, MEASURE = 2'd1, DIVIDE = 2'd2;
  logic [1:0] state;
  logic s1, lvl, lvl_d, rise;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [CNT_W:0] rem, r, diff;
  logic [6:0] quo;
  logic [2:0] it;
  logic ge, timeout;
  assign r = rem << 1;
  assign ge = r >= {1'b0, period_out};
  assign diff = r - {1'b0, period_out};
  assign timeout = state == MEASURE && !rise && cnt == '1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      lvl <= 1'b0;
      lvl_d <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1 <= pwm_in;
      lvl <= s1;
      lvl_d <= lvl;
      rise <= lvl & ~lvl_d;
    end
  end
  // hcnt loads lvl on a rise so a one-cycle-high pulse still measures as 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      hcnt <= '0;
    end else if (!en || timeout || (state == IDLE && !rise)) begin
      cnt <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt <= CNT_W'(1);
      hcnt <= CNT_W'(lvl);
    end else begin
      cnt <= cnt + 1'b1;
      hcnt <= hcnt + CNT_W'(lvl);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      period_out <= '0;
      high_out <= '0;
      duty_out <= '0;
      valid <= 1'b0;
      stuck <= 1'b0;
      overrun <= 1'b0;
      rem <= '0;
      quo <= '0;
      it <= '0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        state <= rise ? MEASURE : IDLE;
      end else if (state == MEASURE) begin
        if (rise) begin
          period_out <= cnt;
          high_out <= hcnt;
          rem <= {1'b0, hcnt};
          quo <= '0;
          it <= '0;
          state <= DIVIDE;
        end else if (timeout) begin
          period_out <= '0;
          high_out <= '0;
          duty_out <= {8{lvl}};
          stuck <= 1'b1;
          valid <= 1'b1;
          state <= IDLE;
        end
      end else if (state == DIVIDE) begin
        rem <= ge ? diff : r;
        quo <= {quo[5:0], ge};
        it <= it + 1'b1;
        overrun <= overrun | rise;
        if (it == 3'd7) begin
          duty_out <= {quo, ge};
          stuck <= 1'b0;
          valid <= 1'b1;
          state <= MEASURE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random PWM waveforms against a time-based
// model of when reports occur and what they contain.
module tb_pwm_capture;
  typedef struct {
    int cyc;
    int p;
    int h;
    int d;
    int st;
  } ev_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, pin = 1'b0;
  int sel = 0;
  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  logic [15:0] p16, h16;
  logic [7:0] d16, p8, h8, d8;
  logic v16, s16, o16, v8, s8, o8;
  ev_t exp_q[$], act_q[$];
  int m_armed = 0, m_prev = 0, m_prev_h = 0, m_cap = 0, m_ovr = 0, m_en = 1;
  ev_t m_last;

  pwm_capture #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pin), .period_out(p16), .high_out(h16),
    .duty_out(d16), .valid(v16), .stuck(s16), .overrun(o16)
  );
  pwm_capture #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pin), .period_out(p8), .high_out(h8),
    .duty_out(d8), .valid(v8), .stuck(s8), .overrun(o8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sel != 0 ? v8 : v16) begin
      ev_t e;
      e.cyc = cyc;
      e.p = sel != 0 ? int'(p8) : int'(p16);
      e.h = sel != 0 ? int'(h8) : int'(h16);
      e.d = sel != 0 ? int'(d8) : int'(d16);
      e.st = sel != 0 ? int'(s8) : int'(s16);
      act_q.push_back(e);
    end
  end

  task automatic chk(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // A rise at cycle t reports the interval since the previous rise, 9 cycles
  // later, unless it lands within the 8 busy cycles after the last capture.
  function automatic void m_rise(input int t, input int h_new);
    ev_t e;
    if (m_en == 0) return;
    if (m_armed == 0) begin
      m_armed = 1;
      m_cap = -1000;
    end else if (t - m_cap <= 8) begin
      m_ovr = 1;
    end else begin
      m_cap = t;
      e.cyc = t + 9;
      e.p = t - m_prev;
      e.h = m_prev_h;
      e.d = (m_prev_h * 256) / (t - m_prev);
      e.st = 0;
      exp_q.push_back(e);
      m_last = e;
    end
    m_prev = t;
    m_prev_h = h_new;
  endfunction

  function automatic void m_drop(input int c);
    while (exp_q.size() > 0 && exp_q[$].cyc > c) void'(exp_q.pop_back());
  endfunction

  function automatic void m_reset(input int now);
    m_drop(now - 1);
    m_armed = 0;
    m_ovr = 0;
    m_en = 1;
    m_last = '{0, 0, 0, 0, 0};
  endfunction

  task automatic wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      pin = 1'b1;
      m_rise(cyc + 3, h);
      tick(h);
      pin = 1'b0;
      tick(p - h);
    end
  endtask

  task automatic hold(input int lv, input int k);
    ev_t e;
    if (lv != 0 && pin == 1'b0) m_rise(cyc + 3, 0);
    pin = lv[0];
    if (m_armed != 0) begin
      e.cyc = m_prev + (sel != 0 ? 256 : 65536);
      e.p = 0;
      e.h = 0;
      e.d = lv != 0 ? 255 : 0;
      e.st = 1;
      exp_q.push_back(e);
      m_last = e;
      m_armed = 0;
    end
    tick(k);
  endtask

  task automatic flush(input string sec);
    tick(30);
    chk({sec, ":count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s:cyc[%0d]", sec, i), act_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s:period[%0d]", sec, i), act_q[i].p, exp_q[i].p);
      chk($sformatf("%s:high[%0d]", sec, i), act_q[i].h, exp_q[i].h);
      chk($sformatf("%s:duty[%0d]", sec, i), act_q[i].d, exp_q[i].d);
      chk($sformatf("%s:stuck[%0d]", sec, i), act_q[i].st, exp_q[i].st);
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    m_reset(cyc);
    tick(2);
    rst = 1'b0;
    tick(3);
  endtask

  initial begin
    m_last = '{0, 0, 0, 0, 0};
    tick(3);
    chk("rst:period", p16, 0);
    chk("rst:high", h16, 0);
    chk("rst:duty", d16, 0);
    chk("rst:valid", v16, 0);
    chk("rst:stuck", s16, 0);
    chk("rst:overrun", o16, 0);
    rst = 1'b0;
    tick(5);
    wave(100, 25, 3);
    flush("basic");
    chk("basic:overrun", o16, m_ovr);
    wave(256, 1, 2);
    wave(256, 255, 2);
    wave(10, 9, 3);
    flush("edges");
    chk("edges:overrun", o16, m_ovr);
    for (int i = 0; i < 4; i++) begin
      int p, h;
      p = $urandom_range(10, 500);
      h = $urandom_range(1, p - 1);
      wave(p, h, 3);
    end
    flush("random");
    chk("random:overrun", o16, m_ovr);
    wave(5, 2, 12);
    flush("fast");
    chk("fast:overrun", o16, m_ovr);
    pulse_rst();
    chk("rst2:overrun", o16, 0);
    sel = 1;
    wave(20, 10, 2);
    hold(1, 300);
    hold(0, 20);
    wave(20, 10, 2);
    hold(0, 300);
    wave(20, 10, 3);
    flush("stuck8");
    sel = 0;
    pulse_rst();
    wave(100, 25, 1);
    pin = 1'b1;
    m_rise(cyc + 3, 25);
    tick(5);
    rst = 1'b1;
    m_reset(cyc);
    #1;
    chk("rstdiv:period", p16, 0);
    chk("rstdiv:high", h16, 0);
    chk("rstdiv:duty", d16, 0);
    chk("rstdiv:valid", v16, 0);
    pin = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);
    wave(100, 25, 3);
    flush("rstdiv");
    wave(150, 50, 2);
    pin = 1'b1;
    m_rise(cyc + 3, 50);
    tick(50);
    pin = 1'b0;
    tick(30);
    en = 1'b0;
    m_drop(cyc);
    m_en = 0;
    m_armed = 0;
    tick(40);
    chk("en_off:period", p16, m_last.p);
    chk("en_off:high", h16, m_last.h);
    chk("en_off:duty", d16, m_last.d);
    en = 1'b1;
    m_en = 1;
    tick(10);
    wave(100, 25, 3);
    flush("en");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
